// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants and a constant-evaluable clog2.
//   FIFO_MODE_STD  : registered read, one cycle latency after ren
//   FIFO_MODE_FWFT : first-word-fall-through, head word presented combinationally
package fifo_pkg;

   localparam int unsigned FIFO_MODE_STD  = 0;
   localparam int unsigned FIFO_MODE_FWFT = 1;

   // Ceiling log2; usable in parameter and port-width expressions.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port memory: one write port, one read port, single clock.
// Ports:
//   clk          clock
//   reset        sync active-high, clears the read register only (contents are not reset)
//   we/waddr/wdata  write port
//   re/raddr     read port; re loads the output register when READ_REG != 0
//   rdata        read data (registered when READ_REG != 0, else asynchronous)
module fifo_ram_sdp
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned DEPTH    = 1024,
   parameter int unsigned READ_REG = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      we,
   input  logic [clog2(DEPTH)-1:0]   waddr,
   input  logic [DATA_W-1:0]         wdata,
   input  logic                      re,
   input  logic [clog2(DEPTH)-1:0]   raddr,
   output logic [DATA_W-1:0]         rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port; storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   generate
      if (READ_REG != 0) begin : g_sync_rd
         // Registered read; holds its last value when re is low.
         always_ff @(posedge clk) begin
            if (reset)   rdata <= '0;
            else if (re) rdata <= mem[raddr];
         end
      end else begin : g_async_rd
         // Look-ahead read: the addressed word is presented immediately.
         assign rdata = mem[raddr];
         logic unused_ok;
         assign unused_ok = ^{1'b0, reset, re};
      end
   endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with FWFT / registered-read modes, occupancy
// count, threshold flags and sticky overflow/underflow errors.
// Ports:
//   clk, reset        clock, sync active-high reset
//   wdata, wen        write data / request
//   ren               read request (pop)
//   err_clr           clears overflow and underflow
//   rdata, rvalid     read data and its valid
//   wfull, rempty     count == DEPTH / count == 0
//   almost_empty      count <= AE_THRESH
//   almost_full       count >= AF_THRESH
//   count             current occupancy
//   overflow          sticky: write attempted while full without a pop
//   underflow         sticky: read attempted while empty
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned AE_THRESH = 4,
   parameter int unsigned AF_THRESH = DEPTH - 4,
   parameter int unsigned FWFT      = FIFO_MODE_STD
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DATA_W-1:0]       wdata,
   input  logic                    wen,
   input  logic                    ren,
   input  logic                    err_clr,
   output logic [DATA_W-1:0]       rdata,
   output logic                    rvalid,
   output logic                    wfull,
   output logic                    rempty,
   output logic                    almost_empty,
   output logic                    almost_full,
   output logic [clog2(DEPTH):0]   count,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int unsigned AW = clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          wr_ok;
   logic          rd_ok;
   logic [CW-1:0] count_next;

   // Acceptance: a full FIFO still takes a write when a pop happens alongside.
   always_comb begin
      wr_ok      = wen & (~wfull | ren);
      rd_ok      = ren & ~rempty;
      count_next = count + CW'(wr_ok) - CW'(rd_ok);
   end

   // Pointers, occupancy, status flags (from count_next, so no lag) and sticky errors.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         rempty       <= 1'b1;
         wfull        <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= (AF_THRESH == 0);
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
         count        <= count_next;
         rempty       <= (count_next == '0);
         wfull        <= (32'(count_next) == DEPTH);
         almost_empty <= (32'(count_next) <= AE_THRESH);
         almost_full  <= (32'(count_next) >= AF_THRESH);
         // A new error outranks a coincident clear.
         overflow     <= (wen & ~wr_ok) | (overflow  & ~err_clr);
         underflow    <= (ren & ~rd_ok) | (underflow & ~err_clr);
      end
   end

   fifo_ram_sdp #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .READ_REG ((FWFT == FIFO_MODE_STD) ? 1 : 0)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (wr_ok),
      .waddr (wr_ptr),
      .wdata (wdata),
      .re    (rd_ok),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   generate
      if (FWFT == FIFO_MODE_STD) begin : g_std_valid
         // rdata becomes valid the edge after an accepted pop.
         always_ff @(posedge clk) begin
            if (reset) rvalid <= 1'b0;
            else       rvalid <= rd_ok;
         end
      end else begin : g_fwft_valid
         // Head word is always on rdata whenever the FIFO holds anything.
         assign rvalid = ~rempty;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: a registered-read instance and an FWFT instance share
// the same stimulus; expected values come from a vector table, hand-written
// corner sequences and a queue scoreboard.
module tb_sync_fifo_param;

   localparam int unsigned DW = 8;
   localparam int unsigned DP = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] wdata;
   logic          wen, ren, err_clr;

   logic [DW-1:0] s_rdata, f_rdata;
   logic          s_rvalid, f_rvalid, s_wfull, f_wfull, s_rempty, f_rempty;
   logic          s_ae, f_ae, s_af, f_af, s_ovf, f_ovf, s_udf, f_udf;
   logic [4:0]    s_count, f_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AE_THRESH(2), .AF_THRESH(14), .FWFT(0)) u_std (
      .clk(clk), .reset(reset), .wdata(wdata), .wen(wen), .ren(ren), .err_clr(err_clr),
      .rdata(s_rdata), .rvalid(s_rvalid), .wfull(s_wfull), .rempty(s_rempty),
      .almost_empty(s_ae), .almost_full(s_af), .count(s_count),
      .overflow(s_ovf), .underflow(s_udf));

   sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AE_THRESH(2), .AF_THRESH(14), .FWFT(1)) u_fwft (
      .clk(clk), .reset(reset), .wdata(wdata), .wen(wen), .ren(ren), .err_clr(err_clr),
      .rdata(f_rdata), .rvalid(f_rvalid), .wfull(f_wfull), .rempty(f_rempty),
      .almost_empty(f_ae), .almost_full(f_af), .count(f_count),
      .overflow(f_ovf), .underflow(f_udf));

   typedef struct {
      logic          wen;
      logic          ren;
      logic [DW-1:0] wdata;
      logic [4:0]    count;
      logic          ae;
      logic          empty;
      logic          rvalid;
      logic [DW-1:0] rdata;
   } vec_t;

   vec_t          vecs[9];
   logic [DW-1:0] sb[$];
   logic [DW-1:0] exp_d;
   logic [DW-1:0] d;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, clock it, sample 1 time unit after the edge.
   task automatic step(input logic w, input logic r, input logic c, input logic [DW-1:0] dat);
      wen = w; ren = r; err_clr = c; wdata = dat;
      @(posedge clk);
      #1;
      wen = 1'b0; ren = 1'b0; err_clr = 1'b0;
   endtask

   initial begin
      //            wen   ren   wdata  count ae    empty rvalid rdata
      vecs[0] = '{1'b1, 1'b0, 8'hA0, 5'd1, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[1] = '{1'b1, 1'b0, 8'hA1, 5'd2, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[2] = '{1'b1, 1'b0, 8'hA2, 5'd3, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[3] = '{1'b1, 1'b0, 8'hA3, 5'd4, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[4] = '{1'b0, 1'b1, 8'h00, 5'd3, 1'b0, 1'b0, 1'b1, 8'hA0};
      vecs[5] = '{1'b0, 1'b1, 8'h00, 5'd2, 1'b1, 1'b0, 1'b1, 8'hA1};
      vecs[6] = '{1'b0, 1'b1, 8'h00, 5'd1, 1'b1, 1'b0, 1'b1, 8'hA2};
      vecs[7] = '{1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b1, 1'b1, 8'hA3};
      vecs[8] = '{1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b1, 1'b0, 8'hA3};

      reset = 1'b1; wen = 1'b0; ren = 1'b0; err_clr = 1'b0; wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      chk("rst_count",  32'(s_count), 32'd0);
      chk("rst_rempty", 32'(s_rempty), 32'd1);
      chk("rst_wfull",  32'(s_wfull), 32'd0);
      chk("rst_ae",     32'(s_ae), 32'd1);
      chk("rst_af",     32'(s_af), 32'd0);
      chk("rst_rvalid", 32'(s_rvalid), 32'd0);
      chk("rst_rdata",  32'(s_rdata), 32'd0);
      chk("rst_ovf",    32'(s_ovf), 32'd0);
      chk("rst_udf",    32'(s_udf), 32'd0);
      chk("rst_f_rvalid", 32'(f_rvalid), 32'd0);

      // Basic write/read table on the registered-read instance
      for (int i = 0; i < 9; i++) begin
         step(vecs[i].wen, vecs[i].ren, 1'b0, vecs[i].wdata);
         chk($sformatf("v%0d_count", i),  32'(s_count),  32'(vecs[i].count));
         chk($sformatf("v%0d_ae", i),     32'(s_ae),     32'(vecs[i].ae));
         chk($sformatf("v%0d_empty", i),  32'(s_rempty), 32'(vecs[i].empty));
         chk($sformatf("v%0d_rvalid", i), 32'(s_rvalid), 32'(vecs[i].rvalid));
         chk($sformatf("v%0d_rdata", i),  32'(s_rdata),  32'(vecs[i].rdata));
      end

      // Fill to DEPTH, overflow, simultaneous push/pop while full, drain
      for (int i = 1; i <= 16; i++) begin
         d = 8'(i + 175);
         sb.push_back(d);
         step(1'b1, 1'b0, 1'b0, d);
         chk($sformatf("fill%0d_count", i), 32'(s_count), 32'(i));
         chk($sformatf("fill%0d_af", i),    32'(s_af),    32'(i >= 14));
         chk($sformatf("fill%0d_wfull", i), 32'(s_wfull), 32'(i == 16));
      end
      chk("full_f_rvalid", 32'(f_rvalid), 32'd1);
      chk("full_f_rdata",  32'(f_rdata),  32'hB0);
      step(1'b1, 1'b0, 1'b0, 8'hEE);
      chk("ovf_set",   32'(s_ovf), 32'd1);
      chk("ovf_set_f", 32'(f_ovf), 32'd1);
      chk("ovf_count", 32'(s_count), 32'd16);
      sb.push_back(8'hC0);
      exp_d = sb.pop_front();
      step(1'b1, 1'b1, 1'b0, 8'hC0);
      chk("fullrw_count",  32'(s_count),  32'd16);
      chk("fullrw_wfull",  32'(s_wfull),  32'd1);
      chk("fullrw_rvalid", 32'(s_rvalid), 32'd1);
      chk("fullrw_rdata",  32'(s_rdata),  32'(exp_d));
      for (int i = 0; i < 16; i++) begin
         exp_d = sb.pop_front();
         chk($sformatf("drain%0d_f_rdata", i), 32'(f_rdata), 32'(exp_d));
         step(1'b0, 1'b1, 1'b0, 8'h00);
         chk($sformatf("drain%0d_s_rdata", i), 32'(s_rdata), 32'(exp_d));
      end
      chk("drain_count",  32'(s_count),  32'd0);
      chk("drain_rempty", 32'(s_rempty), 32'd1);
      chk("ovf_sticky",   32'(s_ovf),    32'd1);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("ovf_clr",   32'(s_ovf), 32'd0);
      chk("ovf_clr_f", 32'(f_ovf), 32'd0);

      // Underflow, write+read on empty, clear, set-wins-over-clear
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk("udf_set",    32'(s_udf),    32'd1);
      chk("udf_rvalid", 32'(s_rvalid), 32'd0);
      chk("udf_count",  32'(s_count),  32'd0);
      step(1'b1, 1'b1, 1'b0, 8'hD0);
      chk("emptyrw_count",    32'(s_count),  32'd1);
      chk("emptyrw_udf",      32'(s_udf),    32'd1);
      chk("emptyrw_rvalid",   32'(s_rvalid), 32'd0);
      chk("emptyrw_rempty",   32'(s_rempty), 32'd0);
      chk("emptyrw_f_rvalid", 32'(f_rvalid), 32'd1);
      chk("emptyrw_f_rdata",  32'(f_rdata),  32'hD0);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("udf_clr", 32'(s_udf), 32'd0);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk("udf_pop_rdata", 32'(s_rdata), 32'hD0);
      chk("udf_pop_count", 32'(s_count), 32'd0);
      step(1'b0, 1'b1, 1'b1, 8'h00);
      chk("udf_setwins",   32'(s_udf), 32'd1);
      chk("udf_setwins_f", 32'(f_udf), 32'd1);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("udf_clr2", 32'(s_udf), 32'd0);

      // FWFT fall-through without ren, then pop
      step(1'b1, 1'b0, 1'b0, 8'h55);
      chk("fwft_rvalid",   32'(f_rvalid), 32'd1);
      chk("fwft_rdata",    32'(f_rdata),  32'h55);
      chk("fwft_s_rvalid", 32'(s_rvalid), 32'd0);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("fwft_hold", 32'(f_rdata), 32'h55);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk("fwft_pop_rvalid", 32'(f_rvalid), 32'd0);
      chk("fwft_s_rvalid2",  32'(s_rvalid), 32'd1);
      chk("fwft_s_rdata",    32'(s_rdata),  32'h55);

      // Wrap-around: half occupancy, 3xDEPTH simultaneous push/pop
      sb.delete();
      for (int i = 0; i < 8; i++) begin
         d = 8'($urandom);
         sb.push_back(d);
         step(1'b1, 1'b0, 1'b0, d);
      end
      for (int i = 0; i < 3 * 16; i++) begin
         d = 8'($urandom);
         sb.push_back(d);
         exp_d = sb.pop_front();
         chk($sformatf("wrap%0d_f", i), 32'(f_rdata), 32'(exp_d));
         step(1'b1, 1'b1, 1'b0, d);
         chk($sformatf("wrap%0d_s", i), 32'(s_rdata), 32'(exp_d));
      end
      chk("wrap_count", 32'(s_count), 32'd8);
      for (int i = 0; i < 8; i++) begin
         exp_d = sb.pop_front();
         chk($sformatf("wdrain%0d_f", i), 32'(f_rdata), 32'(exp_d));
         step(1'b0, 1'b1, 1'b0, 8'h00);
         chk($sformatf("wdrain%0d_s", i), 32'(s_rdata), 32'(exp_d));
      end
      chk("wrap_errs", 32'({s_ovf, s_udf, f_ovf, f_udf}), 32'd0);
      chk("wrap_empty", 32'(s_rempty), 32'd1);

      // Reset mid-operation with count=9
      for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 8'(i + 16));
      chk("pre_rst_count", 32'(s_count), 32'd9);
      reset = 1'b1;
      step(1'b0, 1'b0, 1'b0, 8'h00);
      reset = 1'b0;
      chk("mrst_count",    32'(s_count),  32'd0);
      chk("mrst_rempty",   32'(s_rempty), 32'd1);
      chk("mrst_ae",       32'(s_ae),     32'd1);
      chk("mrst_af",       32'(s_af),     32'd0);
      chk("mrst_wfull",    32'(s_wfull),  32'd0);
      chk("mrst_rvalid",   32'(s_rvalid), 32'd0);
      chk("mrst_rdata",    32'(s_rdata),  32'd0);
      chk("mrst_f_rvalid", 32'(f_rvalid), 32'd0);
      chk("mrst_f_count",  32'(f_count),  32'd0);
      step(1'b1, 1'b0, 1'b0, 8'h77);
      chk("post_rst_f_rdata", 32'(f_rdata), 32'h77);
      chk("post_rst_count",   32'(s_count), 32'd1);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk("post_rst_s_rdata", 32'(s_rdata), 32'h77);
      chk("post_rst_empty",   32'(s_rempty), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
